regfile_sb: RTL and testbench

Parametrised scoreboarded register file for the npc integer pipeline. It provides NUM_RPORTS combinational read ports, one write-back port, and a per-register busy scoreboard. Register 0 is hardwired to zero. Write-back data is bypassed to same-cycle reads. Decode uses it to fetch operands and to detect RAW/WAW hazards against in-flight producers; it sits between the decode/issue stage and write-back.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_rport.sv | 49 ++++
 rtl/regfile_sb.sv | 118 +++++++++++
 tb/tb_regfile_sb.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Package  : regfile_pkg
// Purpose  : Shared defaults and helpers for the scoreboarded register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Default geometry of the integer register file
  localparam int RF_ADDR_W     = 5;
  localparam int RF_DATA_W     = 32;
  localparam int RF_NUM_RPORTS = 2;

  // Index of the hardwired-zero register
  localparam int RF_ZERO_IDX   = 0;

  // Width of the busy population counter: one extra bit over the index width
  function automatic int rf_cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rport.sv
`default_nettype none
// ============================================================================
// Module   : regfile_rport
// Purpose  : One combinational read port: zero register, write-back bypass,
//            array lookup and pending-producer (busy) lookup.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_rport
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0]                         i_raddr,
  input  logic                                          i_wen,    // already masked by reset
  input  logic [ADDR_WIDTH-1:0]                         i_waddr,
  input  logic [DATA_WIDTH-1:0]                         i_wdata,
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]    i_rf,
  input  logic [(2**ADDR_WIDTH)-1:0]                    i_busy,
  output logic [DATA_WIDTH-1:0]                         o_rdata,
  output logic                                          o_rbusy
);

  logic w_is_zero;
  logic w_byp_hit;

  assign w_is_zero = (i_raddr == ADDR_WIDTH'(RF_ZERO_IDX));
  assign w_byp_hit = (BYPASS != 0) && i_wen && (i_waddr == i_raddr);

  // Priority mux: zero register, then same-cycle write-back, then array state
  always_comb begin
    o_rdata = '0;
    o_rbusy = 1'b0;
    if (w_is_zero) begin
      o_rdata = '0;
      o_rbusy = 1'b0;
    end else if (w_byp_hit) begin
      // The producer is completing now, so the source is no longer pending
      o_rdata = i_wdata;
      o_rbusy = 1'b0;
    end else begin
      o_rdata = i_rf[i_raddr];
      o_rbusy = i_busy[i_raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Parametrised register file with N combinational read ports, one
//            write-back port, same-cycle bypass and a per-register busy
//            scoreboard for RAW/WAW hazard detection at decode.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_W,
  parameter int DATA_WIDTH = RF_DATA_W,
  parameter int NUM_RPORTS = RF_NUM_RPORTS,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             iss_en,
  input  logic [ADDR_WIDTH-1:0]            iss_addr,
  output logic                             iss_ready,
  input  logic                             flush,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RPORTS-1:0]            rbusy,
  output logic [ADDR_WIDTH:0]              busy_cnt
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int CNT_W = rf_cnt_width(ADDR_WIDTH);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_rf;
  logic [DEPTH-1:0]                 r_busy;
  logic [CNT_W-1:0]                 r_busy_cnt;

  logic [DEPTH-1:0]                 w_busy_nxt;
  logic [CNT_W-1:0]                 w_cnt_nxt;
  logic                             w_wen_live;
  logic                             w_waddr_nz;
  logic                             w_iss_nz;
  logic                             w_iss_fire;

  // Bypass is disabled while reset is held so reads show the cleared array
  assign w_wen_live = wen & ~reset;
  assign w_waddr_nz = (waddr    != ADDR_WIDTH'(RF_ZERO_IDX));
  assign w_iss_nz   = (iss_addr != ADDR_WIDTH'(RF_ZERO_IDX));

  // WAW stall unless the in-flight producer is retiring this very cycle
  assign iss_ready  = ~w_iss_nz | ~r_busy[iss_addr] | (wen & (waddr == iss_addr));
  assign w_iss_fire = iss_en & iss_ready & w_iss_nz & ~flush;

  assign busy_cnt   = r_busy_cnt;

  // Register array write; index 0 is never written and stays zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rf <= '0;
    end else if (wen && w_waddr_nz) begin
      r_rf[waddr] <= wdata;
    end
  end

  // Next scoreboard state: release on write-back, set on issue (set wins), flush clears all
  always_comb begin
    w_busy_nxt = r_busy;
    if (wen && w_waddr_nz) begin
      w_busy_nxt[waddr] = 1'b0;
    end
    if (w_iss_fire) begin
      w_busy_nxt[iss_addr] = 1'b1;
    end
    if (flush) begin
      w_busy_nxt = '0;
    end
    w_busy_nxt[RF_ZERO_IDX] = 1'b0;
  end

  // Population count of the next scoreboard state, so busy_cnt tracks busy exactly
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_cnt_nxt = w_cnt_nxt + CNT_W'(w_busy_nxt[i]);
    end
  end

  // Scoreboard and its count update together on each edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rport
    regfile_rport #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BYPASS     (BYPASS)
    ) u_rport (
      .i_raddr (raddr[k*ADDR_WIDTH +: ADDR_WIDTH]),
      .i_wen   (w_wen_live),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .i_rf    (r_rf),
      .i_busy  (r_busy),
      .o_rdata (rdata[k*DATA_WIDTH +: DATA_WIDTH]),
      .o_rbusy (rbusy[k])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Self-checking bench for regfile_sb; one instance with bypass and
//            one without, both driven identically and checked against a
//            behavioural model of the register file and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NP    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             flush;
  logic [NP*AW-1:0] raddr;
  logic [NP*DW-1:0] rdata_b, rdata_n;
  logic [NP-1:0]    rbusy_b, rbusy_n;
  logic             ready_b, ready_n;
  logic [AW:0]      cnt_b, cnt_n;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [DW-1:0] m_rf   [DEPTH];
  bit            m_busy [DEPTH];

  always #5 clk = ~clk;

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NP), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(ready_b), .flush(flush),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b), .busy_cnt(cnt_b));

  regfile_sb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NP), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .wen(wen), .waddr(waddr), .wdata(wdata),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_ready(ready_n), .flush(flush),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n), .busy_cnt(cnt_n));

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] exp_rdata(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && !reset && wen && int'(waddr) == a) return wdata;
    return m_rf[a];
  endfunction

  function automatic bit exp_rbusy(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && !reset && wen && int'(waddr) == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic bit exp_ready();
    if (iss_addr == 0) return 1'b1;
    if (wen && waddr == iss_addr) return 1'b1;
    return !m_busy[iss_addr];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i]   = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Advance one clock; model applies the inputs that were held across the edge
  task automatic tick();
    bit rdy;
    bit fire;
    @(posedge clk);
    rdy = exp_ready();
    if (!reset) begin
      fire = iss_en && rdy && (iss_addr != 0) && !flush;
      if (wen && waddr != 0) begin
        m_rf[waddr]   = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (flush) for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      if (fire) m_busy[iss_addr] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    wen = 0; waddr = '0; wdata = '0;
    iss_en = 0; iss_addr = '0; flush = 0;
  endtask

  function automatic logic [NP*AW-1:0] pack2(input int a0, input int a1);
    logic [NP*AW-1:0] r;
    r[0 +: AW]  = AW'(a0);
    r[AW +: AW] = AW'(a1);
    return r;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    int addrs [3] = '{0, 1, 31};
    for (int t = 0; t < 3; t++) begin
      raddr = pack2(addrs[t], addrs[(t + 1) % 3]);
      // writes and issues during reset must be ignored and not bypassed
      wen = 1; waddr = AW'(addrs[t]); wdata = 32'hA5A5_0000 + DW'(t);
      iss_en = 1; iss_addr = AW'(addrs[t]);
      #4;
      n_vec++;
      if (rdata_b !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata_b); end
      n_vec++;
      if (rbusy_b !== '0) begin n_err++; $display("FAIL reset_rbusy: got %b want 0", rbusy_b); end
      n_vec++;
      if (cnt_b !== '0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", cnt_b); end
      n_vec++;
      if (ready_b !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ready_b); end
      tick();
    end
    idle_inputs();
    reset = 0;
    raddr = pack2(1, 31);
    #4;
    n_vec++;
    if (rdata_b !== '0) begin n_err++; $display("FAIL post_reset_rdata: got %h want 0", rdata_b); end
    tick();
  endtask

  task automatic test_bypass();
    wen = 1; waddr = 5; wdata = 32'hDEAD_BEEF;
    raddr = pack2(5, 0);
    #4;
    n_vec++;
    if (rdata_b[0 +: DW] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bypass_same: got %h want deadbeef", rdata_b[0 +: DW]); end
    n_vec++;
    if (rdata_n[0 +: DW] !== 32'h0) begin n_err++; $display("FAIL nobypass_same: got %h want 0", rdata_n[0 +: DW]); end
    tick();
    wen = 0;
    #4;
    n_vec++;
    if (rdata_b[0 +: DW] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL bypass_next: got %h want deadbeef", rdata_b[0 +: DW]); end
    n_vec++;
    if (rdata_n[0 +: DW] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL nobypass_next: got %h want deadbeef", rdata_n[0 +: DW]); end
    tick();
  endtask

  task automatic test_zero_reg();
    wen = 1; waddr = 0; wdata = 32'h1234;
    iss_en = 1; iss_addr = 0;
    raddr = pack2(0, 0);
    #4;
    n_vec++;
    if (rdata_b !== '0) begin n_err++; $display("FAIL zero_bypass: got %h want 0", rdata_b); end
    n_vec++;
    if (ready_b !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b want 1", ready_b); end
    tick();
    idle_inputs();
    #4;
    n_vec++;
    if (rdata_b !== '0 || rdata_n !== '0) begin n_err++; $display("FAIL zero_read: got %h/%h want 0", rdata_b, rdata_n); end
    n_vec++;
    if (cnt_b !== '0) begin n_err++; $display("FAIL zero_cnt: got %0d want 0", cnt_b); end
    tick();
  endtask

  task automatic test_waw();
    iss_en = 1; iss_addr = 7; raddr = pack2(7, 7);
    #4;
    n_vec++;
    if (rbusy_b !== 2'b00) begin n_err++; $display("FAIL waw_preissue_rbusy: got %b want 00", rbusy_b); end
    tick();
    iss_en = 0;
    #4;
    n_vec++;
    if (rbusy_b !== 2'b11) begin n_err++; $display("FAIL waw_rbusy: got %b want 11", rbusy_b); end
    n_vec++;
    if (cnt_b !== 6'd1) begin n_err++; $display("FAIL waw_cnt: got %0d want 1", cnt_b); end
    iss_en = 1;
    #1;
    n_vec++;
    if (ready_b !== 1'b0) begin n_err++; $display("FAIL waw_stall: got %b want 0", ready_b); end
    #3;
    tick();
    iss_en = 0;
    #4;
    n_vec++;
    if (cnt_b !== 6'd1 || rbusy_b !== 2'b11) begin n_err++; $display("FAIL waw_hold: got cnt %0d rbusy %b want 1/11", cnt_b, rbusy_b); end
    wen = 1; waddr = 7; wdata = 32'h0000_00AA; iss_en = 1; iss_addr = 7;
    #1;
    n_vec++;
    if (ready_b !== 1'b1) begin n_err++; $display("FAIL waw_release_ready: got %b want 1", ready_b); end
    n_vec++;
    if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b1) begin n_err++; $display("FAIL waw_release_rbusy: got %b/%b want 0/1", rbusy_b[0], rbusy_n[0]); end
    #3;
    tick();
    idle_inputs();
    #4;
    n_vec++;
    if (rbusy_b[0] !== 1'b1 || cnt_b !== 6'd1) begin n_err++; $display("FAIL waw_reissue: got rbusy %b cnt %0d want 1/1", rbusy_b[0], cnt_b); end
    n_vec++;
    if (rdata_b[0 +: DW] !== 32'h0000_00AA) begin n_err++; $display("FAIL waw_data: got %h want aa", rdata_b[0 +: DW]); end
    wen = 1; waddr = 7; wdata = 32'h0000_00BB;
    tick();
    idle_inputs();
    #4;
    n_vec++;
    if (cnt_b !== '0) begin n_err++; $display("FAIL waw_clear_cnt: got %0d want 0", cnt_b); end
    tick();
  endtask

  task automatic test_flush();
    int dst [3] = '{3, 4, 9};
    for (int i = 0; i < 3; i++) begin
      iss_en = 1; iss_addr = AW'(dst[i]);
      tick();
    end
    iss_en = 0;
    #4;
    n_vec++;
    if (cnt_b !== 6'd3) begin n_err++; $display("FAIL flush_pre_cnt: got %0d want 3", cnt_b); end
    flush = 1; iss_en = 1; iss_addr = 10;
    tick();
    idle_inputs();
    iss_addr = 10;
    raddr = pack2(3, 10);
    #2;
    n_vec++;
    if (rbusy_b !== 2'b00 || cnt_b !== '0) begin n_err++; $display("FAIL flush_clear: got rbusy %b cnt %0d want 00/0", rbusy_b, cnt_b); end
    n_vec++;
    if (ready_b !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", ready_b); end
    raddr = pack2(4, 9);
    #2;
    n_vec++;
    if (rbusy_b !== 2'b00) begin n_err++; $display("FAIL flush_clear2: got %b want 00", rbusy_b); end
    tick();
  endtask

  task automatic test_random();
    int a;
    for (int c = 0; c < 400; c++) begin
      wen      = ($urandom_range(0, 1) == 1);
      waddr    = AW'($urandom_range(0, 15));
      wdata    = $urandom;
      iss_en   = ($urandom_range(0, 1) == 1);
      iss_addr = AW'($urandom_range(0, 15));
      flush    = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < NP; k++)
        raddr[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? waddr : AW'($urandom_range(0, 31));
      #4;
      for (int k = 0; k < NP; k++) begin
        a = int'(raddr[k*AW +: AW]);
        n_vec++;
        if (rdata_b[k*DW +: DW] !== exp_rdata(a, 1'b1)) begin n_err++; $display("FAIL rand_rdata_byp p%0d a%0d: got %h want %h", k, a, rdata_b[k*DW +: DW], exp_rdata(a, 1'b1)); end
        n_vec++;
        if (rdata_n[k*DW +: DW] !== exp_rdata(a, 1'b0)) begin n_err++; $display("FAIL rand_rdata_nob p%0d a%0d: got %h want %h", k, a, rdata_n[k*DW +: DW], exp_rdata(a, 1'b0)); end
        n_vec++;
        if (rbusy_b[k] !== exp_rbusy(a, 1'b1)) begin n_err++; $display("FAIL rand_rbusy_byp p%0d a%0d: got %b want %b", k, a, rbusy_b[k], exp_rbusy(a, 1'b1)); end
        n_vec++;
        if (rbusy_n[k] !== exp_rbusy(a, 1'b0)) begin n_err++; $display("FAIL rand_rbusy_nob p%0d a%0d: got %b want %b", k, a, rbusy_n[k], exp_rbusy(a, 1'b0)); end
      end
      n_vec++;
      if (ready_b !== exp_ready() || ready_n !== exp_ready()) begin n_err++; $display("FAIL rand_ready: got %b/%b want %b", ready_b, ready_n, exp_ready()); end
      n_vec++;
      if (int'(cnt_b) != exp_cnt() || int'(cnt_n) != exp_cnt()) begin n_err++; $display("FAIL rand_cnt: got %0d/%0d want %0d", cnt_b, cnt_n, exp_cnt()); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 4; i++) begin
      wen = 1; waddr = AW'(i); wdata = $urandom | 32'h1;
      iss_en = (i <= 2); iss_addr = AW'(i + 4);
      tick();
    end
    idle_inputs();
    iss_addr = 5;
    raddr = pack2(1, 5);
    #1;
    n_vec++;
    if (rdata_b[0 +: DW] !== m_rf[1] || rbusy_b[1] !== 1'b1) begin n_err++; $display("FAIL arst_pre: got %h/%b want %h/1", rdata_b[0 +: DW], rbusy_b[1], m_rf[1]); end
    #1;
    reset = 1;
    #1;
    model_reset();
    n_vec++;
    if (rdata_b !== '0 || rdata_n !== '0) begin n_err++; $display("FAIL arst_rdata: got %h/%h want 0", rdata_b, rdata_n); end
    n_vec++;
    if (rbusy_b !== '0 || cnt_b !== '0) begin n_err++; $display("FAIL arst_busy: got %b cnt %0d want 0/0", rbusy_b, cnt_b); end
    n_vec++;
    if (ready_b !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %b want 1", ready_b); end
    wen = 1; waddr = 2; wdata = 32'hFFFF_FFFF;
    tick();
    reset = 0;
    idle_inputs();
    for (int p = 0; p < 2; p++) begin
      raddr = pack2(1 + 2 * p, 2 + 2 * p);
      #4;
      n_vec++;
      if (rdata_b !== '0) begin n_err++; $display("FAIL arst_after p%0d: got %h want 0", p, rdata_b); end
      tick();
    end
  endtask

  initial begin
    reset = 1;
    raddr = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_waw();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
